// File: rtl/mixer_accum.sv
`default_nettype none
// ============================================================================
// Module      : mixer_accum
// Description : Multi-channel mix sequencer/accumulator. On each frame
//               strobe it reads NCH (sample, gain) pairs from the channel
//               register file, issues one pair per cycle to an external
//               pipelined Q1.23 multiplier, follows the products with a tag
//               pipeline, and sums them. It then emits one saturated 24-bit
//               mixed sample per frame.
// Revision    : 1.0  initial release
// ============================================================================
module mixer_accum #(
  parameter int NCH        = 4,
  parameter int CH_BITS    = 2,
  parameter int MP_LATENCY = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_i,
  output logic [CH_BITS-1:0] ch_sel_o,
  input  logic [23:0]        sample_i,
  input  logic [23:0]        gain_i,
  output logic [23:0]        mpcand_o,
  output logic [23:0]        mplier_o,
  input  logic [23:0]        mprod_i,
  output logic [23:0]        mix_o,
  output logic               mix_valid_o,
  output logic               busy_o,
  output logic               ovf_o
);

  // The accumulator has enough headroom for NCH full-scale products plus a
  // sign bit, so the running sum never wraps before the final clamp.
  localparam int ACC_W = 24 + CH_BITS + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-24){1'b0}}, 24'h7fffff};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-24){1'b1}}, 24'h800000};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CH_BITS-1:0]        ch_sel_q, ch_sel_d;
  logic [23:0]               mpcand_q, mpcand_d;
  logic [23:0]               mplier_q, mplier_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [23:0]               mix_q, mix_d;
  logic                      mix_valid_q, mix_valid_d;
  logic                      busy_q, busy_d;
  logic                      ovf_q, ovf_d;

  // The operand-stage tag travels alongside mpcand_o/mplier_o. The
  // MP_LATENCY-deep pipeline behind it mirrors the multiplier's internal
  // stages, so the pipeline output lines up with mprod_i.
  logic                      op_valid_q, op_valid_d;
  logic                      op_last_q, op_last_d;
  logic [MP_LATENCY-1:0]     tag_valid_q, tag_valid_d;
  logic [MP_LATENCY-1:0]     tag_last_q, tag_last_d;

  logic                      tag_out_valid;
  logic                      tag_out_last;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      last_ch;

  assign tag_out_valid = tag_valid_q[MP_LATENCY-1];
  assign tag_out_last  = tag_last_q[MP_LATENCY-1];
  assign prod_ext      = {{(ACC_W-24){mprod_i[23]}}, mprod_i};
  assign sum           = acc_q + prod_ext;
  assign last_ch       = (ch_sel_q == CH_BITS'(NCH - 1));

  generate
    if (MP_LATENCY > 1) begin : g_tag_shift
      // Shift the tag pipeline by one stage every cycle.
      always_comb begin
        tag_valid_d = {tag_valid_q[MP_LATENCY-2:0], op_valid_q};
        tag_last_d  = {tag_last_q[MP_LATENCY-2:0], op_last_q};
      end
    end else begin : g_tag_single
      // Single-stage multiplier: the pipeline is one register deep.
      always_comb begin
        tag_valid_d = op_valid_q;
        tag_last_d  = op_last_q;
      end
    end
  endgenerate

  // Sequencer next state, operand issue and product accumulation.
  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    mpcand_d    = '0;
    mplier_d    = '0;
    op_valid_d  = 1'b0;
    op_last_d   = 1'b0;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_i) begin
          state_d  = ST_ISSUE;
          busy_d   = 1'b1;
          acc_d    = '0;
          ch_sel_d = '0;
        end
      end
      ST_ISSUE: begin
        mpcand_d   = sample_i;
        mplier_d   = gain_i;
        op_valid_d = 1'b1;
        op_last_d  = last_ch;
        if (last_ch) begin
          ch_sel_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          ch_sel_d = ch_sel_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Operands stay zero while the remaining products return.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Products are only taken when their tag reaches the pipeline output.
    // The last one closes the frame.
    if (tag_out_valid) begin
      if (tag_out_last) begin
        if (sum > SAT_MAX) begin
          mix_d = 24'h7fffff;
          ovf_d = 1'b1;
        end else if (sum < SAT_MIN) begin
          mix_d = 24'h800000;
          ovf_d = 1'b1;
        end else begin
          mix_d = sum[23:0];
          ovf_d = 1'b0;
        end
        mix_valid_d = 1'b1;
        busy_d      = 1'b0;
        acc_d       = '0;
        state_d     = ST_IDLE;
      end else begin
        acc_d = sum;
      end
    end
  end

  // State registers. Reset also aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_sel_q    <= '0;
      mpcand_q    <= '0;
      mplier_q    <= '0;
      op_valid_q  <= 1'b0;
      op_last_q   <= 1'b0;
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      mpcand_q    <= mpcand_d;
      mplier_q    <= mplier_d;
      op_valid_q  <= op_valid_d;
      op_last_q   <= op_last_d;
      tag_valid_q <= tag_valid_d;
      tag_last_q  <= tag_last_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ch_sel_o    = ch_sel_q;
  assign mpcand_o    = mpcand_q;
  assign mplier_o    = mplier_q;
  assign mix_o       = mix_q;
  assign mix_valid_o = mix_valid_q;
  assign busy_o      = busy_q;
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: doc/mixer_accum.md
Name: mixer_accum

Overview:
Multi-channel mix sequencer/accumulator that drives the pipelined 24-bit Q1.23 signed fractional multiplier (mpemu) and consumes its products.
On each frame strobe it reads NCH (sample, gain) pairs from the channel register file and issues one pair per cycle to the multiplier. It tracks the multiplier's fixed latency with an internal tag pipeline, sums the returned products, saturates the sum to 24 bits, and emits one mixed sample per frame.

Parameters:
NCH, 4, number of channels mixed per frame (power of two, 2..16)
CH_BITS, 2, width of channel index (log2 NCH)
MP_LATENCY, 6, cycles from an operand pair on mpcand_o/mplier_o to its product on mprod_i

Ports:
clk  in  1  system clock (24.576 MHz domain)
rst_n  in  1  reset; one clock; reset is synchronous and active-low
frame_i  in  1  one-cycle start-of-frame strobe
ch_sel_o  out  CH_BITS  channel index to regfile; sample_i/gain_i valid combinationally in same cycle
sample_i  in  24  signed Q1.23 channel sample
gain_i  in  24  signed Q1.23 channel gain
mpcand_o  out  24  multiplicand to multiplier (registered)
mplier_o  out  24  multiplier operand (registered)
mprod_i  in  24  Q1.23 product from multiplier, (a*b)>>>23
mix_o  out  24  saturated mixed sample (registered, held until next frame result)
mix_valid_o  out  1  one-cycle pulse when mix_o updates
busy_o  out  1  high from frame acceptance until mix_valid_o cycle
ovf_o  out  1  high with mix_valid_o if that frame saturated

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, tag pipeline cleared, accumulator 0. Reset mid-frame aborts: no mix_valid_o, mix_o=0.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: ch_sel_o=0, mpcand_o=mplier_o=0. frame_i=1 at edge E0 -> ISSUE, busy_o=1, accumulator cleared.
- ISSUE: at each edge Ek (k=1..NCH), register mpcand_o<=sample_i, mplier_o<=gain_i for ch_sel_o=k-1. Increment ch_sel_o. Push tag {valid=1, last=(k==NCH)} into the MP_LATENCY-deep tag shift register. After E_NCH: -> DRAIN, mpcand_o/mplier_o<=0, push valid=0 tags.
- Tag alignment: the product of the pair registered at Ek is on mprod_i during the cycle after E(k+MP_LATENCY). It is accumulated at E(k+MP_LATENCY+1) when the tag at the pipeline output is valid. Invalid tags leave the accumulator unchanged.
- Accumulator: signed, 24+CH_BITS+1 bits, sign-extended mprod_i added; never wraps.
- Last tag at edge E(NCH+MP_LATENCY+1):
  - mix_o <= sat(acc+mprod_i), with sat clamping to [0x800000, 0x7fffff].
  - ovf_o <= 1 if clamped, else 0.
  - mix_valid_o <= 1 for one cycle; busy_o <= 0; state -> IDLE.
- Defaults: NCH=4, MP_LATENCY=6 -> mix_valid_o in the cycle after E11.
- frame_i while busy_o=1 is ignored: no queueing, no effect on the running frame.
- frame_i in the mix_valid_o cycle is accepted, since the state is already IDLE.
- mix_o and ovf_o hold their values between frames. ovf_o clears on the next mix_valid_o.

Test Plan:
- Gain 0 on ch1..3, ch0 sample 0x100000 gain 0x123456; frame_i -> mix_valid_o 11 cycles after frame edge, mix_o=0x02468a, ovf_o=0, busy_o high exactly 11 cycles.
- All 4 channels sample 0x400000 gain 0x7fffff (each ~0x3fffff) -> sum 0xfffffc clamps, mix_o=0x7fffff, ovf_o=1.
- All 4 channels sample 0x800000 gain 0x7fffff (each 0x800001) -> mix_o=0x800000, ovf_o=1. Then all gains 0 -> mix_o=0x000000, ovf_o=0.
- Mixed signs: ch0 0x123456*0x100000 (+0x02468a), ch1 0xffffff*0x7fffff (0xffffff), ch2/ch3 gain 0 -> mix_o=0x024689.
- frame_i re-pulsed at cycles 3 and 8 of a frame -> ignored: exactly one mix_valid_o, correct value. frame_i in the mix_valid_o cycle -> second frame starts, next mix_valid_o 11 cycles later.
- rst_n low at cycle 5 of a frame -> no mix_valid_o, all outputs 0. A new frame after release produces the correct result with no stale products accumulated.
